// File: rtl/sc_stream_encoder.sv
// sc_stream_encoder: converts a binary ones-count into a 2^width-bit
// stochastic bitstream, one frame per loaded value. The frame position
// counter (counter_sob) is free-running and shared with the downstream
// de-correlator/regenerator.
//
// Handshake: a value transfers on a rising edge where in_valid & in_ready
// and rst is low. in_ready is simply !pending_full straight from a
// register, so it never depends combinationally on in_valid. The
// handshake is independent of enable.
module sc_stream_encoder #(
    parameter int width = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [width:0]   in_value,
    input  logic             in_seq_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] counter_sob,
    output logic             sof,
    output logic             stream_out,
    output logic             frame_active
);

    // Largest meaningful ones-count: every bit of the frame set.
    localparam logic [width:0]   FULL_COUNT = {1'b1, {width{1'b0}}};
    localparam logic [width-1:0] LAST_POS   = '1;

    logic [width:0]   r_pend_val;
    logic             r_pend_sel;
    logic             r_pend_full;
    logic [width:0]   r_act_val;
    logic             r_act_sel;
    logic             r_frame_active;
    logic [width-1:0] r_counter;

    logic [width:0]   w_sat_val;
    logic             w_accept;
    logic             w_boundary;
    logic [width-1:0] w_rev;
    logic [width-1:0] w_key;

    // Clamp requests above the frame length so they mean "all ones".
    always_comb begin
        w_sat_val = in_value;
        if (in_value > FULL_COUNT) begin
            w_sat_val = FULL_COUNT;
        end
    end

    assign w_accept   = in_valid & ~r_pend_full;
    assign w_boundary = enable & (r_counter == LAST_POS);

    // Bit-reversed counter gives the low-discrepancy ordering.
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < width; i++) begin
            w_rev[i] = r_counter[width-1-i];
        end
    end

    assign w_key = r_act_sel ? r_counter : w_rev;

    // Frame counter, pending buffer and active-frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_counter      <= '0;
            r_pend_val     <= '0;
            r_pend_sel     <= 1'b0;
            r_pend_full    <= 1'b0;
            r_act_val      <= '0;
            r_act_sel      <= 1'b0;
            r_frame_active <= 1'b0;
        end else begin
            if (enable) begin
                r_counter <= r_counter + width'(1);
            end
            // Loading and accepting are mutually exclusive: a load needs
            // pending full, an accept needs it empty. A value accepted on
            // the boundary edge therefore waits a whole frame in pending.
            if (w_boundary) begin
                if (r_pend_full) begin
                    r_act_val      <= r_pend_val;
                    r_act_sel      <= r_pend_sel;
                    r_frame_active <= 1'b1;
                    r_pend_full    <= 1'b0;
                end else begin
                    r_act_val      <= '0;
                    r_frame_active <= 1'b0;
                end
            end
            if (w_accept) begin
                r_pend_val  <= w_sat_val;
                r_pend_sel  <= in_seq_sel;
                r_pend_full <= 1'b1;
            end
        end
    end

    assign in_ready     = ~r_pend_full;
    assign counter_sob  = r_counter;
    assign sof          = (r_counter == '0);
    assign frame_active = r_frame_active;
    // Exactly act_val keys in 0..2^width-1 fall below act_val, in either ordering.
    assign stream_out   = r_frame_active & ({1'b0, w_key} < r_act_val);

endmodule

// File: tb/tb_sc_stream_encoder.sv
module tb_sc_stream_encoder;

  logic clk = 1'b0;
  logic rst;

  // width-3 instance
  logic       en3, sel3, valid3, ready3, sof3, so3, fa3;
  logic [3:0] val3;
  logic [2:0] cnt3;
  // width-5 instance
  logic       en5, sel5, valid5, ready5, sof5, so5, fa5;
  logic [5:0] val5;
  logic [4:0] cnt5;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard entries: {seq_sel, saturated value}
  logic [4:0] exp_q3[$];
  logic [6:0] exp_q5[$];

  // monitor state
  bit         m_in_frame = 0;
  int         m_ones;
  logic       m_fa;
  logic [7:0] m_bits;
  bit         m_prev_ok = 0;
  logic       m_prev_en;
  logic [5:0] m_prev_out;
  logic [4:0] m_e;

  sc_stream_encoder #(.width(3)) dut3 (
    .clk(clk), .rst(rst), .enable(en3), .in_value(val3), .in_seq_sel(sel3),
    .in_valid(valid3), .in_ready(ready3), .counter_sob(cnt3), .sof(sof3),
    .stream_out(so3), .frame_active(fa3)
  );

  sc_stream_encoder #(.width(5)) dut5 (
    .clk(clk), .rst(rst), .enable(en5), .in_value(val5), .in_seq_sel(sel5),
    .in_valid(valid5), .in_ready(ready5), .counter_sob(cnt5), .sof(sof5),
    .stream_out(so5), .frame_active(fa5)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] unary3(input int v);
    return 8'((32'd1 << v) - 32'd1);
  endfunction

  function automatic logic [31:0] unary5(input int v);
    return 32'((64'd1 << v) - 64'd1);
  endfunction

  // Scoreboard monitor for the width-3 instance: counts ones per frame,
  // pops expected values for active frames, checks holds while disabled.
  always @(negedge clk) begin
    if (rst) begin
      m_in_frame = 0;
      m_prev_ok  = 0;
    end else begin
      if (m_prev_ok && !m_prev_en) begin
        n_checks++;
        if ({cnt3, sof3, so3, fa3} !== m_prev_out) begin
          n_errors++;
          $display("FAIL hold_while_disabled: got %b required %b", {cnt3, sof3, so3, fa3}, m_prev_out);
        end
      end
      m_prev_ok  = 1;
      m_prev_en  = en3;
      m_prev_out = {cnt3, sof3, so3, fa3};
      if (en3) begin
        if (cnt3 == 3'd0) begin
          m_in_frame = 1;
          m_ones     = 0;
          m_fa       = fa3;
          m_bits     = '0;
        end
        if (m_in_frame) begin
          m_ones += int'(so3);
          m_bits[cnt3] = so3;
          n_checks++;
          if (fa3 !== m_fa) begin
            n_errors++;
            $display("FAIL frame_active_stable: got %b required %b at pos %0d", fa3, m_fa, cnt3);
          end
          if (cnt3 == 3'd7) begin
            m_in_frame = 0;
            n_checks++;
            if (m_fa) begin
              if (exp_q3.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_active_frame: got active frame with %0d ones, required idle", m_ones);
              end else begin
                m_e = exp_q3.pop_front();
                if (m_ones != int'(m_e[3:0])) begin
                  n_errors++;
                  $display("FAIL frame_ones: got %0d required %0d", m_ones, m_e[3:0]);
                end else if (m_e[4] && (m_bits !== unary3(int'(m_e[3:0])))) begin
                  n_errors++;
                  $display("FAIL unary_order: got %b required %b", m_bits, unary3(int'(m_e[3:0])));
                end
              end
            end else if (m_ones != 0) begin
              n_errors++;
              $display("FAIL idle_frame_ones: got %0d required 0", m_ones);
            end
          end
        end
      end
    end
  end

  // driver tasks
  task automatic send3(input logic [3:0] v, input logic s);
    int t;
    t = 0;
    val3 = v; sel3 = s; valid3 = 1'b1;
    while (ready3 !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (ready3 !== 1'b1) begin
      n_errors++;
      $display("FAIL send3_timeout: in_ready %b required 1", ready3);
    end else begin
      exp_q3.push_back({s, (v > 4'd8) ? 4'd8 : v});
    end
    @(posedge clk); #2;
    valid3 = 1'b0;
  endtask

  task automatic wait_cnt3(input logic [2:0] c);
    int t;
    t = 0;
    @(negedge clk);
    while (cnt3 !== c && t < 60) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (cnt3 !== c) begin
      n_errors++;
      $display("FAIL wait_cnt3_timeout: counter_sob %0d required %0d", cnt3, c);
    end
  endtask

  task automatic capture3(output logic [7:0] bits, output logic act);
    wait_cnt3(3'd0);
    act = fa3;
    bits = '0;
    bits[0] = so3;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      bits[i] = so3;
    end
  endtask

  // test tasks
  task automatic test_reset;
    rst = 1'b1; en3 = 1'b1; en5 = 1'b1;
    valid3 = 1'b1; val3 = 4'd5; sel3 = 1'b0;
    valid5 = 1'b0; val5 = '0; sel5 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cnt3, sof3, so3, fa3, ready3} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_state: got cnt=%0d sof=%b so=%b fa=%b rdy=%b required 0 1 0 0 1",
               cnt3, sof3, so3, fa3, ready3);
    end
    valid3 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (cnt3 !== 3'(i % 8) || sof3 !== (i % 8 == 0) || so3 !== 1'b0 || fa3 !== 1'b0 || ready3 !== 1'b1) begin
        n_errors++;
        $display("FAIL idle_cycle_%0d: got cnt=%0d sof=%b so=%b fa=%b rdy=%b required cnt=%0d",
                 i, cnt3, sof3, so3, fa3, ready3, i % 8);
      end
    end
  endtask

  task automatic test_ordering;
    logic [3:0] vals [4] = '{4'd3, 4'd3, 4'd8, 4'd15};
    logic       sels [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] pats [4] = '{8'h15, 8'h07, 8'hFF, 8'hFF};
    logic [7:0] bits;
    logic       act;
    for (int k = 0; k < 4; k++) begin
      wait_cnt3(3'd2);
      send3(vals[k], sels[k]);
      capture3(bits, act);
      n_checks++;
      if (act !== 1'b1 || bits !== pats[k]) begin
        n_errors++;
        $display("FAIL ordering_v%0d_s%0d: got act=%b bits=%b required act=1 bits=%b",
                 vals[k], sels[k], act, bits, pats[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] vals [3] = '{4'd5, 4'd2, 4'd7};
    logic [7:0] bits;
    logic       act;
    int t;
    wait_cnt3(3'd2);
    for (int k = 0; k < 3; k++) begin
      send3(vals[k], 1'($urandom_range(0, 1)));
      @(negedge clk);
      t = 0;
      while (cnt3 != 3'd0 && t < 10) begin
        n_checks++;
        if (ready3 !== 1'b0) begin
          n_errors++;
          $display("FAIL b2b_ready_low: got %b required 0 at pos %0d", ready3, cnt3);
        end
        @(negedge clk);
        t++;
      end
      n_checks++;
      if (ready3 !== 1'b1 || cnt3 !== 3'd0) begin
        n_errors++;
        $display("FAIL b2b_ready_rise: got rdy=%b cnt=%0d required rdy=1 cnt=0", ready3, cnt3);
      end
    end
    capture3(bits, act);
    n_checks++;
    if (act !== 1'b0 || bits !== 8'h00) begin
      n_errors++;
      $display("FAIL b2b_trailing_idle: got act=%b bits=%b required act=0 bits=00000000", act, bits);
    end
  endtask

  task automatic test_random_enable;
    bit done;
    int t;
    done = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          send3(4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
        end
        t = 0;
        while (exp_q3.size() != 0 && t < 2000) begin
          @(negedge clk);
          t++;
        end
        n_checks++;
        if (exp_q3.size() != 0) begin
          n_errors++;
          $display("FAIL random_drain: got %0d frames outstanding required 0", exp_q3.size());
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #2;
          en3 = 1'($urandom_range(0, 1));
        end
        en3 = 1'b1;
      end
    join
  endtask

  task automatic test_reset_mid;
    int bad;
    wait_cnt3(3'd2);
    send3(4'd6, 1'b0);
    wait_cnt3(3'd0);
    n_checks++;
    if (fa3 !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset_setup_active: got %b required 1", fa3);
    end
    send3(4'd4, 1'b1);
    wait_cnt3(3'd4);
    #1 rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q3.delete();
    @(negedge clk);
    n_checks++;
    if (cnt3 !== 3'd0 || sof3 !== 1'b1 || fa3 !== 1'b0 || ready3 !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset_state: got cnt=%0d sof=%b fa=%b rdy=%b required 0 1 0 1",
               cnt3, sof3, fa3, ready3);
    end
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (fa3 !== 1'b0 || so3 !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL mid_reset_discard: got %0d non-idle cycles required 0", bad);
    end
  endtask

  task automatic test_width5;
    logic [31:0] bits;
    logic [6:0]  e;
    int ones, t, inact;
    for (int s = 0; s < 2; s++) begin
      t = 0;
      @(negedge clk);
      while (cnt5 != 5'd2 && t < 80) begin @(negedge clk); t++; end
      val5 = 6'd17; sel5 = 1'(s); valid5 = 1'b1;
      n_checks++;
      if (ready5 !== 1'b1 || cnt5 !== 5'd2) begin
        n_errors++;
        $display("FAIL w5_accept_s%0d: got rdy=%b cnt=%0d required rdy=1 cnt=2", s, ready5, cnt5);
      end else begin
        exp_q5.push_back({1'(s), 6'd17});
      end
      @(posedge clk); #2;
      valid5 = 1'b0;
      t = 0;
      @(negedge clk);
      while (cnt5 != 5'd0 && t < 80) begin @(negedge clk); t++; end
      ones = 0; bits = '0; inact = 0;
      for (int i = 0; i < 32; i++) begin
        if (i > 0) @(negedge clk);
        bits[i] = so5;
        ones += int'(so5);
        if (fa5 !== 1'b1) inact++;
      end
      n_checks++;
      if (exp_q5.size() == 0) begin
        n_errors++;
        $display("FAIL w5_no_expected_s%0d: got %0d ones with empty queue", s, ones);
      end else begin
        e = exp_q5.pop_front();
        if (inact != 0 || ones != int'(e[5:0]) || (e[6] && bits !== unary5(int'(e[5:0])))) begin
          n_errors++;
          $display("FAIL w5_frame_s%0d: got ones=%0d inactive=%0d bits=%h required ones=%0d inactive=0",
                   s, ones, inact, bits, e[5:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_ordering;
    test_back_to_back;
    test_random_enable;
    test_reset_mid;
    test_width5;
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q3.size() != 0) begin
      n_errors++;
      $display("FAIL final_queue_empty: got %0d outstanding required 0", exp_q3.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sc_stream_encoder.md
# sc_stream_encoder

Binary-to-stochastic transmitter for the stochastic-computing datapath: accepts a binary ones-count over a valid/ready handshake and emits it as a 2^width-cycle bitstream. It drives the frame position counter `counter_sob` with the bitstream, so it is the source end of the link whose sink is the bitstream de-correlator / regenerator. It supports low-discrepancy (bit-reversed) and unary (ones-first) bit ordering, selectable per frame.

## Interface
- `width`, 5: frame length is 2^width bits; `counter_sob` width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  advance frame; when 0, counter and frame state hold.
- `in_value`  in  width+1  requested ones-count, 0..2^width; larger values saturate to 2^width.
- `in_seq_sel`  in  1  ordering for this value: 0 = bit-reversed key, 1 = plain counter key.
- `in_valid`  in  1  `in_value`/`in_seq_sel` are valid.
- `in_ready`  out  1  pending buffer empty; transfer on `in_valid & in_ready` at a rising edge.
- `counter_sob`  out  width  bit position in the current frame; 0 = first bit.
- `sof`  out  1  start of frame, `counter_sob == 0`.
- `stream_out`  out  1  stochastic bit for the current position.
- `frame_active`  out  1  current frame carries a loaded value; 0 = idle frame of zeros.

## Operation
- Registers: `pend_val`(width+1), `pend_sel`, `pend_full`; `act_val`(width+1), `act_sel`, `frame_active`; `counter_sob`.
- Accept: on an edge with `in_valid & in_ready` and `rst` low: `pend_val <= sat(in_value)`, `pend_sel <= in_seq_sel`, `pend_full <= 1`. The handshake runs regardless of `enable`.
- `in_ready = !pend_full`, from a register only; no combinational path from `in_valid`.
- Counter: free-running. Each edge with `enable=1` does `counter_sob <= counter_sob + 1`, wrapping from 2^width-1 to 0.
- Frame boundary: an edge with `enable=1` and `counter_sob == 2^width-1`.
  - If `pend_full`: `act_val <= pend_val`, `act_sel <= pend_sel`, `frame_active <= 1`, `pend_full <= 0`.
  - Otherwise: `act_val <= 0`, `frame_active <= 0`.
- No bypass: a value accepted on the boundary edge itself goes to pending, not active.
- Key: `key = act_sel ? counter_sob : rev(counter_sob)`, where `rev` reverses the bit order.
- Output: `stream_out = frame_active & (key < act_val)`, combinational from registers only.
- Bit count: an active frame carries exactly `act_val` ones. A value of 2^width gives all ones; a value of 0 gives all zeros.
- `sof = (counter_sob == 0)`.

## Timing
- Reset values:
  - outputs: `counter_sob=0`, `sof=1`, `stream_out=0`, `frame_active=0`, `in_ready=1`;
  - internal: `pend_full=0`, `act_val=0`.
- Transfers with `rst` high are ignored.
- Reset mid-frame discards both the pending and the active value. The next frame starts at `counter_sob=0` on the first enabled edge after reset deasserts.
- Latency: a value accepted at edge E appears from the first boundary edge after E. Its first bit is visible the cycle after that boundary edge, with `counter_sob=0` and `sof=1`.
- Boundary with pending full and `in_valid=1`:
  - `in_ready` is 0 during that cycle, so no transfer happens;
  - `in_ready` rises the cycle after the boundary, and the next value can be accepted then.
- Throughput: one value per frame, provided a new value is accepted before each boundary edge.
- `enable=0` on a boundary cycle defers the load until the next enabled boundary edge.
- `enable=0` freezes `stream_out`, `sof` and `counter_sob`, since all three derive from held registers.

## Test plan
Width 3 (frame of 8) unless noted.
- Reset then no input: 16 enabled cycles -> `stream_out` all 0, `frame_active=0`, `counter_sob` runs 0..7,0..7, `sof` high at 0, `in_ready=1`.
- `in_value=3`, `in_seq_sel=0` accepted at `counter_sob=2` -> next frame `stream_out` = 1,0,1,0,1,0,0,0 and `frame_active=1`.
- `in_value=3`, `in_seq_sel=1` -> next frame = 1,1,1,0,0,0,0,0. Then `in_value=8` -> all ones. Then `in_value=15` -> saturates, all ones.
- Back-to-back values 5,2,7:
  - `in_ready` is 0 from each accept until the next boundary;
  - successive frames carry exactly 5, 2 and 7 ones;
  - the frame after the last value is idle.
- `enable` toggled randomly with random values:
  - ones per active frame equal the loaded value;
  - no load happens on a disabled boundary cycle;
  - outputs hold while disabled.
- `rst` asserted at `counter_sob=4` with pending and active values loaded -> the next cycle shows `counter_sob=0`, `frame_active=0`, `in_ready=1`, and the discarded values are never emitted. Repeat with width 5: value 17 yields 17 ones per 32-bit frame in both orderings.
